// File: rtl/axis_rom_reader_pkg.sv
// Shared types and sizing helpers for the ROM stream reader.
// Latency: n/a. Backpressure: n/a.
package axis_rom_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Prefetch depth needed to cover the ROM round trip plus one beat of slack.
   function automatic int fifo_depth(input int rom_latency);
      return rom_latency + 2;
   endfunction

   localparam int DEF_DEPTH    = 33;
   localparam int DEF_LATENCY  = 2;
   localparam int DEF_ADDR_W   = $clog2(DEF_DEPTH);
   localparam int DEF_LEN_W    = $clog2(DEF_DEPTH + 1);
   localparam int DEF_FIFO_CNT = $clog2(DEF_LATENCY + 3);

endpackage

// File: rtl/rom_prefetch_fifo.sv
// First-word-fall-through FIFO holding returned ROM words and their last tag.
// Latency: written word visible at the head the cycle after the write.
// Backpressure: a write into a full FIFO is accepted only together with a read.
module rom_prefetch_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_dat,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_dat,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_wr, do_rd;

   assign empty  = (count_q == '0);
   assign full   = (count_q == CW'(DEPTH));
   assign do_rd  = rd_en && !empty;
   assign do_wr  = wr_en && (!full || do_rd);
   assign rd_dat = mem[rd_ptr_q];
   assign count  = count_q;

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr_q] <= wr_dat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
         if (do_rd) rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
         case ({do_wr, do_rd})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/axis_rom_stream_reader.sv
// Streams a (base, len) window of a fixed-latency ROM, repeated N passes, onto a valid/ready port.
// Latency: first beat ROM_MEMORY_LATENCY+2 cycles after start. Backpressure: credit-limited prefetch, 1 beat/cycle.
// Backpressure: reads stall when in-flight plus buffered words reach the prefetch depth.
module axis_rom_stream_reader
   import axis_rom_reader_pkg::*;
#(
   parameter int WIDTH              = 32,
   parameter int DEPTH              = 33,
   parameter int ROM_MEMORY_LATENCY = 2,
   parameter int MAX_REPEAT         = 16,
   parameter int LAST_EACH_PASS     = 0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [$clog2(DEPTH)-1:0]          cfg_base,
   input  logic [$clog2(DEPTH+1)-1:0]        cfg_len,
   input  logic [$clog2(MAX_REPEAT+1)-1:0]   cfg_repeat,
   output logic                              busy,
   output logic                              done,
   output logic                              rom_en,
   output logic [$clog2(DEPTH)-1:0]          rom_addr,
   input  logic [WIDTH-1:0]                  rom_data,
   input  logic                              ds_next_data,
   output logic [WIDTH-1:0]                  ds_out,
   output logic                              ds_valid,
   output logic                              ds_last
);

   localparam int L  = ROM_MEMORY_LATENCY;
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int RW = $clog2(MAX_REPEAT + 1);
   localparam int FD = fifo_depth(L);
   localparam int CW = $clog2(FD + 1);
   localparam logic [CW:0] FD_V = (CW+1)'(FD);

   state_t        state_q;
   logic [AW-1:0] base_q, addr_q;
   logic [LW-1:0] len_m1_q, word_q;
   logic [RW-1:0] rep_m1_q, pass_q;
   logic [L-1:0]  tag_vld_q, tag_last_q;
   logic [CW-1:0] out_cnt_q, fifo_cnt;
   logic          busy_q, done_q;
   logic          issue, end_of_pass, final_pass, issue_last;
   logic          fifo_full, fifo_empty, pop, final_pop;
   logic [WIDTH:0] fifo_head;

   assign end_of_pass = (word_q == len_m1_q);
   assign final_pass  = (pass_q == rep_m1_q);
   assign issue_last  = end_of_pass && ((LAST_EACH_PASS != 0) || final_pass);
   assign issue       = (state_q == ISSUE) && !fifo_full &&
                        (({1'b0, out_cnt_q} + {1'b0, fifo_cnt}) < FD_V);
   assign pop         = !fifo_empty && ds_next_data;
   // Every word is either in flight or buffered, so one buffered word and nothing in flight is the end.
   assign final_pop   = pop && (state_q == DRAIN) && (out_cnt_q == '0) && (fifo_cnt == CW'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         base_q     <= '0;
         addr_q     <= '0;
         len_m1_q   <= '0;
         word_q     <= '0;
         rep_m1_q   <= '0;
         pass_q     <= '0;
         tag_vld_q  <= '0;
         tag_last_q <= '0;
         out_cnt_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q        <= 1'b0;
         tag_vld_q[0]  <= issue;
         tag_last_q[0] <= issue && issue_last;
         for (int i = 1; i < L; i++) begin
            tag_vld_q[i]  <= tag_vld_q[i-1];
            tag_last_q[i] <= tag_last_q[i-1];
         end
         out_cnt_q <= out_cnt_q + CW'(issue) - CW'(tag_vld_q[L-1]);

         case (state_q)
            IDLE: begin
               if (start) begin
                  if (cfg_len == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q  <= ISSUE;
                     busy_q   <= 1'b1;
                     base_q   <= cfg_base;
                     addr_q   <= cfg_base;
                     len_m1_q <= cfg_len - LW'(1);
                     word_q   <= '0;
                     pass_q   <= '0;
                     rep_m1_q <= (cfg_repeat == '0) ? '0 : cfg_repeat - RW'(1);
                  end
               end
            end
            ISSUE: begin
               if (issue) begin
                  if (end_of_pass) begin
                     word_q <= '0;
                     addr_q <= base_q;
                     if (final_pass) state_q <= DRAIN;
                     else if (pass_q != RW'(MAX_REPEAT)) pass_q <= pass_q + RW'(1);
                  end else begin
                     word_q <= word_q + LW'(1);
                     addr_q <= (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
                  end
               end
            end
            DRAIN: begin
               if (final_pop) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   rom_prefetch_fifo #(
      .WIDTH (WIDTH + 1),
      .DEPTH (FD)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (tag_vld_q[L-1]),
      .wr_dat ({tag_last_q[L-1], rom_data}),
      .rd_en  (ds_next_data),
      .rd_dat (fifo_head),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_cnt)
   );

   assign busy     = busy_q;
   assign done     = done_q;
   assign rom_en   = issue;
   assign rom_addr = addr_q;
   assign ds_valid = !fifo_empty;
   assign ds_last  = !fifo_empty && fifo_head[WIDTH];
   assign ds_out   = fifo_empty ? '0 : fifo_head[WIDTH-1:0];

endmodule

// File: tb/tb_axis_rom_stream_reader.sv
// Directed bench: two readers (last per request / last per pass) fed by identical stimulus and ROM models.
module tb_axis_rom_stream_reader;

   localparam int DEPTH = 33;

   logic        clk = 1'b0;
   logic        rst, start, ds_next_data;
   logic [5:0]  cfg_base, cfg_len;
   logic [4:0]  cfg_repeat;
   logic        busy0, done0, rom_en0, ds_valid0, ds_last0;
   logic        busy1, done1, rom_en1, ds_valid1, ds_last1;
   logic [5:0]  rom_addr0, rom_addr1;
   logic [31:0] rom_data0, rom_data1, ds_out0, ds_out1;
   logic [31:0] rp0 [2];
   logic [31:0] rp1 [2];

   always #5 clk = ~clk;

   axis_rom_stream_reader #(.LAST_EACH_PASS(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
      .cfg_repeat(cfg_repeat), .busy(busy0), .done(done0), .rom_en(rom_en0),
      .rom_addr(rom_addr0), .rom_data(rom_data0), .ds_next_data(ds_next_data),
      .ds_out(ds_out0), .ds_valid(ds_valid0), .ds_last(ds_last0));

   axis_rom_stream_reader #(.LAST_EACH_PASS(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
      .cfg_repeat(cfg_repeat), .busy(busy1), .done(done1), .rom_en(rom_en1),
      .rom_addr(rom_addr1), .rom_data(rom_data1), .ds_next_data(ds_next_data),
      .ds_out(ds_out1), .ds_valid(ds_valid1), .ds_last(ds_last1));

   function automatic logic [31:0] rom_word(input int a);
      return 32'hA5A5_0000 + 32'(a) * 32'h0001_0101;
   endfunction

   // Two-cycle ROM; unread cycles return a poison word.
   always @(posedge clk) begin
      rp0[0] <= rom_en0 ? rom_word(int'(rom_addr0)) : 32'hDEAD_BEEF;
      rp0[1] <= rp0[0];
      rp1[0] <= rom_en1 ? rom_word(int'(rom_addr1)) : 32'hDEAD_BEEF;
      rp1[1] <= rp1[0];
   end
   assign rom_data0 = rp0[1];
   assign rom_data1 = rp1[1];

   int total = 0, bad = 0;
   int cyc = 0, c0 = 0;
   int first_en, first_valid, last_beat_cyc, done_cyc, done_cnt, done1_cnt;
   bit busy_seen, busy_at1, busy_at_done, hold_pend, hold_last;
   logic [31:0] hold_dat;
   logic [31:0] dq0[$], dq1[$];
   bit lq0[$], lq1[$];
   int addrs[$];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic clear_log();
      first_en = -1; first_valid = -1; last_beat_cyc = -1; done_cyc = -1;
      done_cnt = 0; done1_cnt = 0; busy_seen = 0; busy_at1 = 0; busy_at_done = 1;
      hold_pend = 0;
      dq0.delete(); dq1.delete(); lq0.delete(); lq1.delete(); addrs.delete();
   endtask

   // Observe at the falling edge what the next rising edge will act on, then advance.
   task automatic tick(input logic rdy);
      ds_next_data = rdy;
      if (hold_pend) begin
         check_val("hold_vld", ds_valid0, 1);
         check_val("hold_dat", ds_out0, hold_dat);
         check_val("hold_last", ds_last0, hold_last);
      end
      hold_pend = !rst && ds_valid0 && !rdy;
      hold_dat  = ds_out0;
      hold_last = ds_last0;
      if (!rst) begin
         if (rom_en0) begin
            addrs.push_back(int'(rom_addr0));
            if (first_en < 0) first_en = cyc;
         end
         if (ds_valid0 && first_valid < 0) first_valid = cyc;
         if (ds_valid0 && rdy) begin
            dq0.push_back(ds_out0); lq0.push_back(ds_last0); last_beat_cyc = cyc;
         end
         if (ds_valid1 && rdy) begin
            dq1.push_back(ds_out1); lq1.push_back(ds_last1);
         end
         if (done0) begin
            done_cnt++;
            if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy0; end
         end
         if (done1) done1_cnt++;
         if (busy0) busy_seen = 1;
         if (cyc == c0 + 1) busy_at1 = busy0;
      end
      @(negedge clk);
      cyc++;
   endtask

   // mode 0: ready high; 1: ready every other cycle; 2: ready low until 10 cycles after first valid.
   task automatic run_req(input int base, input int len, input int rep, input int mode,
                          input int extra_start, input int rst_at);
      int n;
      logic rdy;
      clear_log();
      cfg_base = 6'(base); cfg_len = 6'(len); cfg_repeat = 5'(rep);
      start = 1'b1;
      c0 = cyc;
      tick(1'b1);
      start = 1'b0;
      cfg_base = 6'd7; cfg_len = 6'd2; cfg_repeat = 5'd9;
      n = 0;
      while (done_cnt == 0 && n < 300) begin
         if (rst_at > 0 && dq0.size() == rst_at) begin
            rst = 1'b1;
            tick(1'b1);
            rst = 1'b0;
            check_val("rst_busy", busy0, 0);
            check_val("rst_done", done0, 0);
            check_val("rst_rom_en", rom_en0, 0);
            check_val("rst_rom_addr", rom_addr0, 0);
            check_val("rst_valid", ds_valid0, 0);
            check_val("rst_last", ds_last0, 0);
            check_val("rst_out", ds_out0, 0);
            return;
         end
         case (mode)
            1:       rdy = n[0];
            2:       rdy = (first_valid >= 0) && (cyc >= first_valid + 10);
            default: rdy = 1'b1;
         endcase
         if (mode == 2 && first_valid >= 0 && cyc == first_valid + 10)
            check_val("stall_issued", addrs.size(), 4);
         if (extra_start > 0 && n == extra_start) begin
            start = 1'b1; cfg_base = 6'd0; cfg_len = 6'd20; cfg_repeat = 5'd1;
         end else begin
            start = 1'b0;
         end
         tick(rdy);
         n++;
      end
      start = 1'b0;
      check_val("done_seen", done_cnt != 0, 1);
      for (int i = 0; i < 6; i++) tick(1'b1);
   endtask

   task automatic verify(input int base, input int len, input int rep, input bit contiguous);
      int nb, w;
      nb = len * ((rep == 0) ? 1 : rep);
      check_val("beats", dq0.size(), nb);
      check_val("beats_lep", dq1.size(), nb);
      check_val("rom_reads", addrs.size(), nb);
      check_val("done_once", done_cnt, 1);
      check_val("done_once_lep", done1_cnt, 1);
      for (int k = 0; k < nb; k++) begin
         w = k % len;
         if (k < addrs.size()) check_val("rom_addr", addrs[k], (base + w) % DEPTH);
         if (k < dq0.size()) begin
            check_val("data", dq0[k], rom_word((base + w) % DEPTH));
            check_val("last", lq0[k], k == nb - 1);
         end
         if (k < dq1.size()) begin
            check_val("data_lep", dq1[k], rom_word((base + w) % DEPTH));
            check_val("last_lep", lq1[k], w == len - 1);
         end
      end
      if (nb > 0) begin
         check_val("lat_rom_en", first_en - c0, 1);
         check_val("lat_valid", first_valid - c0, 4);
         check_val("busy_rise", busy_at1, 1);
         check_val("done_after_last", done_cyc - last_beat_cyc, 1);
         check_val("busy_fall", busy_at_done, 0);
         if (contiguous) check_val("contiguous", last_beat_cyc - first_valid, nb - 1);
      end else begin
         check_val("zero_done_lat", done_cyc - c0, 1);
         check_val("zero_no_read", first_en < 0, 1);
         check_val("zero_no_valid", first_valid < 0, 1);
         check_val("zero_no_busy", busy_seen, 0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; ds_next_data = 1'b0;
      cfg_base = '0; cfg_len = '0; cfg_repeat = '0;
      clear_log();
      tick(1'b0);
      tick(1'b0);
      check_val("reset_busy", busy0, 0);
      check_val("reset_done", done0, 0);
      check_val("reset_rom_en", rom_en0, 0);
      check_val("reset_rom_addr", rom_addr0, 0);
      check_val("reset_valid", ds_valid0, 0);
      check_val("reset_last", ds_last0, 0);
      check_val("reset_out", ds_out0, 0);
      rst = 1'b0;
      tick(1'b0);

      run_req(0, 33, 1, 0, 0, 0);  verify(0, 33, 1, 1);
      run_req(0, 33, 1, 1, 0, 0);  verify(0, 33, 1, 0);
      run_req(30, 6, 1, 2, 0, 0);  verify(30, 6, 1, 0);
      run_req(5, 3, 3, 0, 0, 0);   verify(5, 3, 3, 1);
      run_req(3, 0, 1, 0, 0, 0);   verify(3, 0, 1, 0);
      run_req(5, 3, 1, 0, 3, 0);   verify(5, 3, 1, 1);
      run_req(1, 4, 0, 0, 0, 0);   verify(1, 4, 0, 1);

      run_req(0, 33, 1, 0, 0, 10);
      for (int i = 0; i < 8; i++) tick(1'b1);
      check_val("no_stale_beat", dq0.size(), 10);
      check_val("no_stale_done", done_cnt, 0);
      run_req(0, 33, 1, 0, 0, 0);  verify(0, 33, 1, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
